// File: rtl/led_pattern_driver_pkg.sv
// Shared encodings and pattern helpers for the LED pattern driver.
package led_pattern_driver_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_ROTL   = 2'd1,
      MODE_ROTR   = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   function automatic logic [3:0] rot_left(input logic [3:0] p);
      return {p[2:0], p[3]};
   endfunction

   function automatic logic [3:0] rot_right(input logic [3:0] p);
      return {p[0], p[3:1]};
   endfunction

endpackage

// File: rtl/led_pattern_driver_if.sv
// Command/display bundle between a pattern source and the LED driver.
interface led_pattern_driver_if;
   logic [3:0] data;
   logic [1:0] mode;
   logic       load;
   logic       stop;
   logic [3:0] leds;
   logic       tick;

   modport master (
      output data, mode, load, stop,
      input  leds, tick
   );

   modport slave (
      input  data, mode, load, stop,
      output leds, tick
   );
endinterface

// File: rtl/led_pattern_driver_prescaler_tick.sv
// Free-running step prescaler: one tick every 2^PRESC_BITS enabled clocks.
module prescaler_tick #(
   parameter int PRESC_BITS = 22
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic tick
);

   logic [PRESC_BITS-1:0] cnt;

   // Disabled counter is parked at zero so a fresh run always starts a full period.
   always_ff @(posedge clk) begin
      if (!rstn)
         cnt <= '0;
      else if (clr || !en)
         cnt <= '0;
      else
         cnt <= cnt + PRESC_BITS'(1);
   end

   assign tick = en && (&cnt);

endmodule

// File: rtl/led_pattern_driver.sv
// Latches a 4-bit pattern on load and shows it static, rotating or blinking.
module led_pattern_driver
   import led_pattern_driver_pkg::*;
#(
   parameter int PRESC_BITS = 22
) (
   input  logic                 clk,
   input  logic                 rstn,
   led_pattern_driver_if.slave  bus
);

   state_t     state, state_nxt;
   mode_t      mode_r, mode_nxt;
   logic [3:0] pattern, pattern_nxt;
   logic [3:0] leds, leds_nxt;
   logic       phase, phase_nxt;
   logic       step;
   logic       clr;

   prescaler_tick #(.PRESC_BITS(PRESC_BITS)) u_presc (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clr),
      .en   (state == RUN),
      .tick (step)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= IDLE;
         mode_r  <= MODE_STATIC;
         pattern <= '0;
         leds    <= '0;
         phase   <= 1'b1;
      end else begin
         state   <= state_nxt;
         mode_r  <= mode_nxt;
         pattern <= pattern_nxt;
         leds    <= leds_nxt;
         phase   <= phase_nxt;
      end
   end

   // Priority: load > stop > step; a step coinciding with load or stop is dropped.
   always_comb begin
      state_nxt   = state;
      mode_nxt    = mode_r;
      pattern_nxt = pattern;
      leds_nxt    = leds;
      phase_nxt   = phase;
      clr         = 1'b0;
      if (bus.load) begin
         state_nxt   = RUN;
         mode_nxt    = mode_t'(bus.mode);
         pattern_nxt = bus.data;
         leds_nxt    = bus.data;
         phase_nxt   = 1'b1;
         clr         = 1'b1;
      end else if (state == RUN && bus.stop) begin
         state_nxt = IDLE;
         leds_nxt  = '0;
         clr       = 1'b1;
      end else if (step) begin
         case (mode_r)
            MODE_ROTL: begin
               pattern_nxt = rot_left(pattern);
               leds_nxt    = rot_left(pattern);
            end
            MODE_ROTR: begin
               pattern_nxt = rot_right(pattern);
               leds_nxt    = rot_right(pattern);
            end
            MODE_BLINK: begin
               phase_nxt = ~phase;
               leds_nxt  = (~phase) ? pattern : 4'b0000;
            end
            default: ;
         endcase
      end
   end

   assign bus.leds = leds;
   assign bus.tick = step;

endmodule
